// File: rtl/zbuf_depth_test.sv
// Depth buffer: embedded Z memory, two-edge depth-test/update pipeline with
// write-to-read forwarding, and a clear sequencer that sweeps the whole memory.
module zbuf_depth_test #(
    parameter int unsigned    ADDR_W      = 16,
    parameter int unsigned    Z_W         = 24,
    parameter int unsigned    COLOR_W     = 24,
    parameter logic [Z_W-1:0] CLEAR_VALUE = '1,
    parameter int unsigned    CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic [1:0]         cmp_mode,
    input  logic               z_write_en,
    input  logic               frag_valid,
    output logic               frag_ready,
    input  logic [ADDR_W-1:0]  frag_addr,
    input  logic [Z_W-1:0]     frag_z,
    input  logic [COLOR_W-1:0] frag_color,
    output logic               pass_valid,
    output logic [ADDR_W-1:0]  pass_addr,
    output logic [COLOR_W-1:0] pass_color,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] MODE_LESS   = 2'd0;
    localparam logic [1:0] MODE_LEQUAL = 2'd1;
    localparam logic [1:0] MODE_ALWAYS = 2'd2;
    localparam logic [1:0] MODE_NEVER  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                clr_done_q, clr_done_d;
    logic                clr_we;

    logic [Z_W-1:0]      mem [DEPTH];
    logic [Z_W-1:0]      rd_z_q;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [Z_W-1:0]      mem_wdata;

    logic                s1_vld_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [Z_W-1:0]      s1_z_q;
    logic [COLOR_W-1:0]  s1_color_q;
    logic [1:0]          s1_mode_q;
    logic                s1_zwe_q;
    logic                s1_fwd_q;
    logic [Z_W-1:0]      s1_fwd_z_q;
    logic [Z_W-1:0]      s1_stored;
    logic                s1_pass;
    logic                s1_wr;

    logic                pass_valid_q;
    logic [ADDR_W-1:0]   pass_addr_q;
    logic [COLOR_W-1:0]  pass_color_q;
    logic [CNT_W-1:0]    pass_cnt_q;
    logic [CNT_W-1:0]    fail_cnt_q;

    logic                accept;
    logic                fwd_hit;

    assign frag_ready = (state_q == ST_IDLE);
    assign accept     = frag_valid & frag_ready;

    // ---------------- clear sequencer ----------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_done_d = 1'b0;
        clr_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d    = ST_DRAIN;
                    clr_addr_d = '0;
                end
            end
            ST_DRAIN: begin
                // The write port belongs to stage 1 until it empties.
                if (!s1_vld_q) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (&clr_addr_q) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign clear_busy = (state_q != ST_IDLE);
    assign clear_done = clr_done_q;

    // ---------------- depth memory ----------------
    assign mem_we    = s1_wr | clr_we;
    assign mem_waddr = clr_we ? clr_addr_q : s1_addr_q;
    assign mem_wdata = clr_we ? CLEAR_VALUE : s1_z_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (accept) rd_z_q <= mem[frag_addr];
    end

    // ---------------- stage 1: compare and update ----------------
    // The memory read issued alongside a stage-1 write sees the old value,
    // so the writing fragment's Z is captured for the follower instead.
    assign fwd_hit   = s1_wr & (s1_addr_q == frag_addr);
    assign s1_stored = s1_fwd_q ? s1_fwd_z_q : rd_z_q;

    always_comb begin
        s1_pass = 1'b0;
        case (s1_mode_q)
            MODE_LESS:   s1_pass = (s1_z_q <  s1_stored);
            MODE_LEQUAL: s1_pass = (s1_z_q <= s1_stored);
            MODE_ALWAYS: s1_pass = 1'b1;
            MODE_NEVER:  s1_pass = 1'b0;
            default:     s1_pass = 1'b0;
        endcase
    end

    assign s1_wr = s1_vld_q & s1_pass & s1_zwe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_z_q     <= '0;
            s1_color_q <= '0;
            s1_mode_q  <= MODE_NEVER;
            s1_zwe_q   <= 1'b0;
            s1_fwd_q   <= 1'b0;
            s1_fwd_z_q <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_addr_q  <= frag_addr;
                s1_z_q     <= frag_z;
                s1_color_q <= frag_color;
                s1_mode_q  <= cmp_mode;
                s1_zwe_q   <= z_write_en;
                s1_fwd_q   <= fwd_hit;
                s1_fwd_z_q <= s1_z_q;
            end
        end
    end

    // ---------------- outputs and statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_valid_q <= 1'b0;
            pass_addr_q  <= '0;
            pass_color_q <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            pass_valid_q <= s1_vld_q & s1_pass;
            if (s1_vld_q & s1_pass) begin
                pass_addr_q  <= s1_addr_q;
                pass_color_q <= s1_color_q;
            end
            if (s1_vld_q) begin
                if (s1_pass) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
                else         fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pass_valid = pass_valid_q;
    assign pass_addr  = pass_addr_q;
    assign pass_color = pass_color_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_zbuf_depth_test.sv
// Bench for zbuf_depth_test: serialised depth-buffer model checked every
// cycle, plus directed vectors with literal expectations.
module tb_zbuf_depth_test;

    localparam int AW    = 8;
    localparam int ZW    = 24;
    localparam int CW    = 24;
    localparam int NW    = 32;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] LESS = 2'd0, LEQUAL = 2'd1, ALWAYS = 2'd2, NEVER = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic [1:0]    cmp_mode = LESS;
    logic          z_write_en = 1'b1;
    logic          frag_valid = 1'b0;
    logic          frag_ready;
    logic [AW-1:0] frag_addr = '0;
    logic [ZW-1:0] frag_z = '0;
    logic [CW-1:0] frag_color = '0;
    logic          pass_valid;
    logic [AW-1:0] pass_addr;
    logic [CW-1:0] pass_color;
    logic [NW-1:0] pass_cnt, fail_cnt;

    zbuf_depth_test #(.ADDR_W(AW), .Z_W(ZW), .COLOR_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .cmp_mode(cmp_mode), .z_write_en(z_write_en),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_addr(frag_addr), .frag_z(frag_z), .frag_color(frag_color),
        .pass_valid(pass_valid), .pass_addr(pass_addr), .pass_color(pass_color),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            pv;
        logic [AW-1:0] a;
        logic [CW-1:0] c;
        logic [NW-1:0] pc;
        logic [NW-1:0] fc;
    } exp_t;

    logic [ZW-1:0] mz [DEPTH];
    logic [NW-1:0] m_pc, m_fc;
    exp_t          q1, q2;

    function automatic bit zpass(input logic [1:0] m, input logic [ZW-1:0] z, input logic [ZW-1:0] s);
        case (m)
            LESS:    return z < s;
            LEQUAL:  return z <= s;
            ALWAYS:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Fragments are applied one at a time in acceptance order; results are
    // due two edges after acceptance.
    initial begin
        bit p;
        m_pc = '0; m_fc = '0;
        q1 = '{pv: 1'b0, a: '0, c: '0, pc: '0, fc: '0};
        q2 = q1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_pc = '0; m_fc = '0;
                q1 = '{pv: 1'b0, a: '0, c: '0, pc: '0, fc: '0};
                q2 = q1;
            end else begin
                chk("cmp_pass_valid", pass_valid, q2.pv);
                if (q2.pv) begin
                    chk("cmp_pass_addr", pass_addr, q2.a);
                    chk("cmp_pass_color", pass_color, q2.c);
                end
                chk("cmp_pass_cnt", pass_cnt, q2.pc);
                chk("cmp_fail_cnt", fail_cnt, q2.fc);
                q2 = q1;
                if (frag_valid && frag_ready) begin
                    p = zpass(cmp_mode, frag_z, mz[frag_addr]);
                    if (p) begin
                        m_pc = m_pc + 1;
                        if (z_write_en) mz[frag_addr] = frag_z;
                    end else begin
                        m_fc = m_fc + 1;
                    end
                    q1 = '{pv: p, a: frag_addr, c: frag_color, pc: m_pc, fc: m_fc};
                end else begin
                    q1 = '{pv: 1'b0, a: '0, c: '0, pc: m_pc, fc: m_fc};
                end
                if (clear_start && !clear_busy)
                    for (int i = 0; i < DEPTH; i++) mz[i] = '1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [ZW-1:0] z, input logic [CW-1:0] c,
                         input logic [1:0] m, input logic we);
        frag_valid = 1'b1; frag_addr = a; frag_z = z; frag_color = c;
        cmp_mode = m; z_write_en = we;
    endtask

    // One fragment; returns just after its E1 so pass_valid is observable.
    task automatic send(input logic [AW-1:0] a, input logic [ZW-1:0] z, input logic [CW-1:0] c,
                        input logic [1:0] m, input logic we);
        drive(a, z, c, m, we);
        tick();
        frag_valid = 1'b0;
        tick();
    endtask

    task automatic do_clear(input bit traffic, input int want_lat);
        int j;
        bit ok;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("clr_busy_start", clear_busy, 1);
        chk("clr_ready_start", frag_ready, 0);
        j = 0;
        ok = 1'b1;
        while (!clear_done && j < DEPTH + 10) begin
            tick();
            j++;
            if (traffic && j == 1) begin
                frag_z = '1; cmp_mode = LESS;
            end
            if (!clear_done && (!clear_busy || frag_ready)) ok = 1'b0;
        end
        chk("clr_latency", j, want_lat);
        chk("clr_busy_ready_during", ok, 1);
        chk("clr_busy_at_done", clear_busy, 0);
        tick();
        chk("clr_done_one_cycle", clear_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit quiet;
        repeat (3) tick();
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_pass_valid", pass_valid, 0);
        chk("rst_pass_addr", pass_addr, 0);
        chk("rst_pass_color", pass_color, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_frag_ready", frag_ready, 1);
        rst = 1'b0;
        tick();

        // Clear then single fragment
        do_clear(1'b0, DEPTH + 1);
        send(8'h10, 24'h000100, 24'hFF0000, LESS, 1'b1);
        chk("t1_pass_valid", pass_valid, 1);
        chk("t1_pass_addr", pass_addr, 8'h10);
        chk("t1_pass_color", pass_color, 24'hFF0000);
        chk("t1_pass_cnt", pass_cnt, 1);

        // Depth rejection then LEQUAL on equal Z
        send(8'h10, 24'h000200, 24'h00FF00, LESS, 1'b1);
        chk("t2_pass_valid", pass_valid, 0);
        chk("t2_fail_cnt", fail_cnt, 1);
        send(8'h10, 24'h000100, 24'h0000FF, LEQUAL, 1'b1);
        chk("t2_leq_pass_valid", pass_valid, 1);
        chk("t2_leq_color", pass_color, 24'h0000FF);
        chk("t2_pass_cnt", pass_cnt, 2);

        // Back-to-back same-address hazard
        do_clear(1'b0, DEPTH + 1);
        drive(8'h05, 24'h50, 24'h000001, LESS, 1'b1);
        tick();
        drive(8'h05, 24'h40, 24'h000002, LESS, 1'b1);
        tick();
        chk("t3_f1_pass", pass_valid, 1);
        drive(8'h05, 24'h60, 24'h000003, LESS, 1'b1);
        tick();
        chk("t3_f2_pass", pass_valid, 1);
        chk("t3_f2_color", pass_color, 24'h000002);
        drive(8'h05, 24'h41, 24'h000004, LESS, 1'b1);
        tick();
        chk("t3_f3_fail", pass_valid, 0);
        frag_valid = 1'b0;
        tick();
        chk("t3_f4_fail", pass_valid, 0);
        chk("t3_pass_cnt", pass_cnt, 4);
        chk("t3_fail_cnt", fail_cnt, 3);

        // Modes and z_write_en=0
        send(8'h09, 24'hFFFFFF, 24'h111111, ALWAYS, 1'b1);
        chk("t4_always", pass_valid, 1);
        send(8'h09, 24'h000000, 24'h222222, NEVER, 1'b1);
        chk("t4_never", pass_valid, 0);
        drive(8'h20, 24'h10, 24'h333333, LESS, 1'b0);
        tick();
        drive(8'h20, 24'h20, 24'h444444, LESS, 1'b1);
        tick();
        chk("t4_nowrite_pass", pass_valid, 1);
        frag_valid = 1'b0;
        tick();
        chk("t4_old_value_pass", pass_valid, 1);
        chk("t4_old_value_color", pass_color, 24'h444444);
        chk("t4_pass_cnt", pass_cnt, 7);
        chk("t4_fail_cnt", fail_cnt, 4);

        // Clear with traffic: fragment on the request edge completes first
        drive(8'h30, 24'h10, 24'hABCDEF, ALWAYS, 1'b1);
        do_clear(1'b1, DEPTH + 2);
        frag_valid = 1'b0;
        tick();
        chk("t5_held_fail", pass_valid, 0);
        chk("t5_pass_cnt", pass_cnt, 8);
        chk("t5_fail_cnt", fail_cnt, 5);
        send(8'h10, 24'hFFFFFF, 24'h0, LESS, 1'b1);
        chk("t5_a10_fail", pass_valid, 0);
        send(8'h05, 24'hFFFFFF, 24'h0, LESS, 1'b1);
        chk("t5_a05_fail", pass_valid, 0);
        send(8'hFF, 24'hFFFFFF, 24'h0, LESS, 1'b1);
        chk("t5_aff_fail", pass_valid, 0);
        send(8'h05, 24'hFFFFFE, 24'h555555, LESS, 1'b1);
        chk("t5_a05_near_far_pass", pass_valid, 1);
        chk("t5_fail_cnt2", fail_cnt, 8);

        // Asynchronous reset in the middle of a clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (101) tick();
        chk("t6_busy_before_rst", clear_busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", clear_busy, 0);
        chk("t6_rst_done", clear_done, 0);
        chk("t6_rst_pass_valid", pass_valid, 0);
        chk("t6_rst_pass_addr", pass_addr, 0);
        chk("t6_rst_pass_color", pass_color, 0);
        chk("t6_rst_pass_cnt", pass_cnt, 0);
        chk("t6_rst_fail_cnt", fail_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        quiet = 1'b1;
        repeat (DEPTH) begin
            tick();
            if (clear_done || clear_busy || !frag_ready) quiet = 1'b0;
        end
        chk("t6_no_done_after_rst", quiet, 1);
        do_clear(1'b0, DEPTH + 1);
        send(8'h64, 24'h000005, 24'h666666, LESS, 1'b1);
        chk("t6_post_pass_valid", pass_valid, 1);
        chk("t6_post_pass_cnt", pass_cnt, 1);
        chk("t6_post_fail_cnt", fail_cnt, 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
